// File: rtl/wb_soc_arbiter.sv
// -----------------------------------------------------------------------------
// wb_soc_arbiter
//
// Three-master Wishbone B4 classic arbiter sitting in front of the SoC
// peripheral decode (CLINT/PLIC/UART/CRG). m0 = core, m1 = caravel,
// m2 = testio. Grants rotate round-robin and are held for the whole bus cycle
// (granted cyc high). Exactly one idle cycle separates consecutive grants.
//
// Optional feature macro: WB_ARB_TIMEOUT_EN
//   When defined, a watchdog counts stalled strobe cycles. On reaching
//   TIMEOUT_CYCLES it terminates the access with a forced ack carrying
//   32'hDEAD_BEEF, pulses timeout_o, and parks in DRAIN until the master
//   releases cyc. When undefined, timeout_o is tied low and a hung slave
//   stalls the bus.
//
// Ports:
//   clk, rst                 peripheral clock, asynchronous active-low reset
//   m{0,1,2}_cyc_i/stb_i/we_i, m{0,1,2}_addr_i/wdata_i/sel_i
//                            master requests
//   m{0,1,2}_rdata_o/ack_o   read data / acknowledge back to each master
//   s_cyc_o/stb_o/we_o, s_addr_o/wdata_o/sel_o
//                            shared slave-side request (granted master's)
//   s_rdata_i, s_ack_i       slave response
//   grant_o                  one-hot current grant, 0 when idle
//   timeout_o                one-cycle pulse on watchdog termination
// -----------------------------------------------------------------------------
module wb_soc_arbiter #(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_cyc_i,
   input  logic              m0_stb_i,
   input  logic              m0_we_i,
   input  logic [AW-1:0]     m0_addr_i,
   input  logic [DW-1:0]     m0_wdata_i,
   input  logic [DW/8-1:0]   m0_sel_i,
   output logic [DW-1:0]     m0_rdata_o,
   output logic              m0_ack_o,
   input  logic              m1_cyc_i,
   input  logic              m1_stb_i,
   input  logic              m1_we_i,
   input  logic [AW-1:0]     m1_addr_i,
   input  logic [DW-1:0]     m1_wdata_i,
   input  logic [DW/8-1:0]   m1_sel_i,
   output logic [DW-1:0]     m1_rdata_o,
   output logic              m1_ack_o,
   input  logic              m2_cyc_i,
   input  logic              m2_stb_i,
   input  logic              m2_we_i,
   input  logic [AW-1:0]     m2_addr_i,
   input  logic [DW-1:0]     m2_wdata_i,
   input  logic [DW/8-1:0]   m2_sel_i,
   output logic [DW-1:0]     m2_rdata_o,
   output logic              m2_ack_o,
   output logic              s_cyc_o,
   output logic              s_stb_o,
   output logic              s_we_o,
   output logic [AW-1:0]     s_addr_o,
   output logic [DW-1:0]     s_wdata_o,
   output logic [DW/8-1:0]   s_sel_o,
   input  logic [DW-1:0]     s_rdata_i,
   input  logic              s_ack_i,
   output logic [2:0]        grant_o,
   output logic              timeout_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
`ifdef WB_ARB_TIMEOUT_EN
   localparam logic [1:0] S_DRAIN = 2'd2;
`endif

   // Parameter sanity check at elaboration.
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("wb_soc_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   logic [1:0]      r_state;
   logic [1:0]      w_next_state;
   logic [2:0]      r_grant;
   // Index of the most recent grant. While a grant is held it is also the
   // index of the current owner, so it doubles as the mux select.
   logic [1:0]      r_last;

   logic [2:0]      w_req;
   logic            w_any;
   logic [1:0]      w_win;

   logic            w_g_cyc;
   logic            w_g_stb;
   logic            w_g_we;
   logic [AW-1:0]   w_g_addr;
   logic [DW-1:0]   w_g_wdata;
   logic [DW/8-1:0] w_g_sel;

   logic            w_in_grant;
   logic            w_timeout;
   logic            w_route;
   logic            w_ack_g;
   logic [DW-1:0]   w_rd_g;

   assign w_in_grant = (r_state == S_GRANT);

   // Round-robin pick: search starts at the master after the last grant.
   always_comb begin
      w_req = {m2_cyc_i, m1_cyc_i, m0_cyc_i};
      w_any = |w_req;
      w_win = 2'd0;
      case (r_last)
         2'd0: begin
            if (w_req[1])      w_win = 2'd1;
            else if (w_req[2]) w_win = 2'd2;
            else               w_win = 2'd0;
         end
         2'd1: begin
            if (w_req[2])      w_win = 2'd2;
            else if (w_req[0]) w_win = 2'd0;
            else               w_win = 2'd1;
         end
         default: begin
            if (w_req[0])      w_win = 2'd0;
            else if (w_req[1]) w_win = 2'd1;
            else               w_win = 2'd2;
         end
      endcase
   end

   // Owner's request signals.
   always_comb begin
      w_g_cyc   = 1'b0;
      w_g_stb   = 1'b0;
      w_g_we    = 1'b0;
      w_g_addr  = '0;
      w_g_wdata = '0;
      w_g_sel   = '0;
      case (r_last)
         2'd0: begin
            w_g_cyc = m0_cyc_i; w_g_stb = m0_stb_i; w_g_we = m0_we_i;
            w_g_addr = m0_addr_i; w_g_wdata = m0_wdata_i; w_g_sel = m0_sel_i;
         end
         2'd1: begin
            w_g_cyc = m1_cyc_i; w_g_stb = m1_stb_i; w_g_we = m1_we_i;
            w_g_addr = m1_addr_i; w_g_wdata = m1_wdata_i; w_g_sel = m1_sel_i;
         end
         2'd2: begin
            w_g_cyc = m2_cyc_i; w_g_stb = m2_stb_i; w_g_we = m2_we_i;
            w_g_addr = m2_addr_i; w_g_wdata = m2_wdata_i; w_g_sel = m2_sel_i;
         end
         default: ;
      endcase
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] r_cnt;

   // Fires in the cycle the stall count has reached the limit while the
   // owner is still strobing; that same cycle carries the forced ack.
   assign w_timeout = w_in_grant && w_g_cyc && w_g_stb &&
                      (r_cnt == CW'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (!w_in_grant || (w_next_state != S_GRANT) || s_ack_i) begin
         r_cnt <= '0;
      end else if (w_g_cyc && w_g_stb) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   // Slave path is live only while granted and not being terminated.
   assign w_route = w_in_grant && !w_timeout;

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_any) w_next_state = S_GRANT;
         end
         S_GRANT: begin
`ifdef WB_ARB_TIMEOUT_EN
            if (w_timeout)     w_next_state = S_DRAIN;
            else if (!w_g_cyc) w_next_state = S_IDLE;
`else
            if (!w_g_cyc)      w_next_state = S_IDLE;
`endif
         end
`ifdef WB_ARB_TIMEOUT_EN
         S_DRAIN: begin
            if (!w_g_cyc) w_next_state = S_IDLE;
         end
`endif
         default: w_next_state = S_IDLE;
      endcase
   end

   // Grant and round-robin pointer; pointer updates only on a new grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_grant <= 3'b000;
         r_last  <= 2'd2;
      end else if ((r_state == S_IDLE) && w_any) begin
         r_grant <= 3'b001 << w_win;
         r_last  <= w_win;
      end else if (w_next_state == S_IDLE) begin
         r_grant <= 3'b000;
      end
   end

   // FSM outputs.
   always_comb begin
      s_cyc_o   = w_route & w_g_cyc;
      s_stb_o   = w_route & w_g_cyc & w_g_stb;
      s_we_o    = w_route & w_g_we;
      s_addr_o  = w_route ? w_g_addr  : '0;
      s_wdata_o = w_route ? w_g_wdata : '0;
      s_sel_o   = w_route ? w_g_sel   : '0;

      w_ack_g = w_route ? s_ack_i : w_timeout;
      w_rd_g  = '0;
      if (w_timeout)    w_rd_g = DW'(32'hDEAD_BEEF);
      else if (w_route) w_rd_g = s_rdata_i;

      m0_ack_o   = r_grant[0] & w_ack_g;
      m1_ack_o   = r_grant[1] & w_ack_g;
      m2_ack_o   = r_grant[2] & w_ack_g;
      m0_rdata_o = r_grant[0] ? w_rd_g : '0;
      m1_rdata_o = r_grant[1] ? w_rd_g : '0;
      m2_rdata_o = r_grant[2] ? w_rd_g : '0;

      grant_o   = r_grant;
      timeout_o = w_timeout;
   end

endmodule

// File: tb/tb_wb_soc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_soc_arbiter
//
// Self-checking bench for wb_soc_arbiter: a reset check, a cycle table of
// simultaneous requests, hand-written multi-cycle sequences, and a randomized
// run compared every cycle against an owner/pointer reference model.
// Define WB_ARB_TIMEOUT_EN on the command line to exercise the watchdog
// (TIMEOUT_CYCLES is overridden to 8).
// -----------------------------------------------------------------------------
module tb_wb_soc_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;
`ifdef WB_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [2:0]    cyc, stb, we;
   logic [AW-1:0] addr  [3];
   logic [DW-1:0] wdata [3];
   logic [3:0]    sel   [3];
   logic          s_ack;
   logic [DW-1:0] s_rdata;

   logic [DW-1:0] rd_o [3];
   logic [2:0]    ack_o;
   logic          s_cyc, s_stb, s_we;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_wdata;
   logic [3:0]    s_sel;
   logic [2:0]    grant;
   logic          tout;

   always #5 clk = ~clk;

   wb_soc_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]),
      .m0_addr_i(addr[0]), .m0_wdata_i(wdata[0]), .m0_sel_i(sel[0]),
      .m0_rdata_o(rd_o[0]), .m0_ack_o(ack_o[0]),
      .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]),
      .m1_addr_i(addr[1]), .m1_wdata_i(wdata[1]), .m1_sel_i(sel[1]),
      .m1_rdata_o(rd_o[1]), .m1_ack_o(ack_o[1]),
      .m2_cyc_i(cyc[2]), .m2_stb_i(stb[2]), .m2_we_i(we[2]),
      .m2_addr_i(addr[2]), .m2_wdata_i(wdata[2]), .m2_sel_i(sel[2]),
      .m2_rdata_o(rd_o[2]), .m2_ack_o(ack_o[2]),
      .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
      .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_sel_o(s_sel),
      .s_rdata_i(s_rdata), .s_ack_i(s_ack),
      .grant_o(grant), .timeout_o(tout)
   );

   int n_err = 0;
   int n_chk = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: owner index (-1 = bus idle), last-granted index,
   // stalled-strobe count and a draining flag.
   int  mo, ml, mc;
   bit  md, m_tnow;

   logic [2:0]    e_grant, e_ack;
   logic [DW-1:0] e_rd [3];
   logic          e_scyc, e_sstb, e_swe, e_to;
   logic [AW-1:0] e_saddr;
   logic [DW-1:0] e_swdata;
   logic [3:0]    e_ssel;

   task automatic model_reset();
      mo = -1; ml = 2; mc = 0; md = 1'b0; m_tnow = 1'b0;
   endtask

   task automatic model_eval();
      e_grant = '0; e_ack = '0; e_scyc = 0; e_sstb = 0; e_swe = 0; e_to = 0;
      e_saddr = '0; e_swdata = '0; e_ssel = '0;
      for (int i = 0; i < 3; i++) e_rd[i] = '0;
      m_tnow = 1'b0;
      if (mo >= 0) begin
         e_grant[mo] = 1'b1;
         if (!md) begin
            m_tnow = TO_EN && (mc == TO) && cyc[mo] && stb[mo];
            if (m_tnow) begin
               e_to = 1'b1;
               e_ack[mo] = 1'b1;
               e_rd[mo] = 32'hDEAD_BEEF;
            end else begin
               e_scyc = cyc[mo];
               e_sstb = cyc[mo] & stb[mo];
               e_swe = we[mo];
               e_saddr = addr[mo];
               e_swdata = wdata[mo];
               e_ssel = sel[mo];
               e_ack[mo] = s_ack;
               e_rd[mo] = s_rdata;
            end
         end
      end
   endtask

   task automatic model_update();
      bit found;
      found = 1'b0;
      if (mo < 0) begin
         for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (ml + k) % 3;
            if (!found && cyc[idx]) begin
               found = 1'b1;
               mo = idx;
               ml = idx;
               mc = 0;
            end
         end
      end else if (md) begin
         if (!cyc[mo]) begin mo = -1; md = 1'b0; end
      end else if (m_tnow) begin
         md = 1'b1; mc = 0;
      end else if (!cyc[mo]) begin
         mo = -1; mc = 0;
      end else if (s_ack) begin
         mc = 0;
      end else if (stb[mo]) begin
         mc++;
      end
   endtask

   logic [2:0]    sn_grant, sn_ack;
   logic [DW-1:0] sn_rd [3];
   logic          sn_scyc, sn_sstb, sn_swe, sn_to;
   logic [AW-1:0] sn_saddr;
   logic [DW-1:0] sn_swdata;
   logic [3:0]    sn_ssel;

   // One clock: compare at the falling edge, advance the model at the rising
   // edge, return just after it so the caller can drive the next inputs.
   task automatic tick();
      @(negedge clk);
      model_eval();
      sn_grant = grant; sn_ack = ack_o; sn_scyc = s_cyc; sn_sstb = s_stb;
      sn_swe = s_we; sn_saddr = s_addr; sn_swdata = s_wdata; sn_ssel = s_sel;
      sn_to = tout;
      for (int i = 0; i < 3; i++) sn_rd[i] = rd_o[i];
      chk("grant", sn_grant, e_grant);
      chk("m_ack", sn_ack, e_ack);
      chk("m0_rdata", sn_rd[0], e_rd[0]);
      chk("m1_rdata", sn_rd[1], e_rd[1]);
      chk("m2_rdata", sn_rd[2], e_rd[2]);
      chk("s_cyc", sn_scyc, e_scyc);
      chk("s_stb", sn_sstb, e_sstb);
      chk("s_we", sn_swe, e_swe);
      chk("s_addr", sn_saddr, e_saddr);
      chk("s_wdata", sn_swdata, e_swdata);
      chk("s_sel", sn_ssel, e_ssel);
      chk("timeout", sn_to, e_to);
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic drain_all();
      cyc = '0; stb = '0; s_ack = 1'b0;
      repeat (3) tick();
   endtask

   typedef struct {
      logic [2:0] cyc;
      logic       ack;
      logic [2:0] e_grant;
      logic       e_scyc;
      logic [2:0] e_ack;
   } vec_t;

   vec_t tbl [10];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   initial begin
      int m1_acks, other_acks, stalled, ntos;
      bit seen;
      bit just_acked [3];
      logic [2:0] prev_g;
      logic [2:0] gq [$];
      logic [AW-1:0] exp_addr;
      bit act [3];
      int beats [3];

      tbl[0] = '{3'b111, 1'b0, 3'b000, 1'b0, 3'b000};
      tbl[1] = '{3'b111, 1'b1, 3'b001, 1'b1, 3'b001};
      tbl[2] = '{3'b110, 1'b0, 3'b001, 1'b0, 3'b000};
      tbl[3] = '{3'b110, 1'b1, 3'b000, 1'b0, 3'b000};
      tbl[4] = '{3'b110, 1'b1, 3'b010, 1'b1, 3'b010};
      tbl[5] = '{3'b100, 1'b0, 3'b010, 1'b0, 3'b000};
      tbl[6] = '{3'b100, 1'b0, 3'b000, 1'b0, 3'b000};
      tbl[7] = '{3'b100, 1'b1, 3'b100, 1'b1, 3'b100};
      tbl[8] = '{3'b000, 1'b0, 3'b100, 1'b0, 3'b000};
      tbl[9] = '{3'b000, 1'b1, 3'b000, 1'b0, 3'b000};

      rst = 1'b0; cyc = '0; stb = '0; we = '0; s_ack = 1'b0; s_rdata = '0;
      for (int i = 0; i < 3; i++) begin
         addr[i] = 32'h1000_0000 + 32'(i * 256);
         wdata[i] = 32'h5500_0000 + 32'(i);
         sel[i] = 4'hF;
      end
      model_reset();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_grant", grant, 3'b000);
      chk("rst_s_cyc", s_cyc, 1'b0);
      chk("rst_s_addr", s_addr, '0);
      chk("rst_ack", ack_o, 3'b000);
      chk("rst_rdata0", rd_o[0], '0);
      chk("rst_timeout", tout, 1'b0);
      rst = 1'b1;

      // Simultaneous requests from reset: 001, 010, 100 with idle gaps
      for (int k = 0; k < 10; k++) begin
         cyc = tbl[k].cyc; stb = tbl[k].cyc; s_ack = tbl[k].ack;
         s_rdata = 32'hA5A5_0000 + 32'(k);
         tick();
         exp_addr = (tbl[k].e_grant == 3'b001) ? addr[0] :
                    (tbl[k].e_grant == 3'b010) ? addr[1] :
                    (tbl[k].e_grant == 3'b100) ? addr[2] : '0;
         chk($sformatf("tbl%0d_grant", k), sn_grant, tbl[k].e_grant);
         chk($sformatf("tbl%0d_s_cyc", k), sn_scyc, tbl[k].e_scyc);
         chk($sformatf("tbl%0d_ack", k), sn_ack, tbl[k].e_ack);
         chk($sformatf("tbl%0d_s_addr", k), sn_saddr, exp_addr);
      end

      // m0 and m2 re-requesting: grants alternate starting with m0
      for (int i = 0; i < 3; i++) just_acked[i] = 1'b0;
      s_ack = 1'b1; prev_g = '0;
      for (int k = 0; k < 40 && gq.size() < 6; k++) begin
         cyc = {!just_acked[2], 1'b0, !just_acked[0]};
         stb = cyc;
         tick();
         for (int i = 0; i < 3; i++) just_acked[i] = sn_ack[i] && cyc[i];
         if (sn_grant != 3'b000 && prev_g == 3'b000) gq.push_back(sn_grant);
         prev_g = sn_grant;
      end
      chk("alt_count", gq.size(), 6);
      for (int k = 0; k < gq.size(); k++)
         chk($sformatf("alt_grant%0d", k), gq[k], (k % 2 == 0) ? 3'b001 : 3'b100);
      drain_all();

      // m1 single write, slave acks two cycles after strobe
      m1_acks = 0; other_acks = 0;
      addr[1] = 32'h0200_0000; wdata[1] = 32'h1234_5678; sel[1] = 4'hF; we = 3'b010;
      cyc = 3'b010; stb = 3'b010; s_ack = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (c == 3) s_ack = 1'b1;
         if (c == 4) begin s_ack = 1'b0; cyc = '0; stb = '0; end
         tick();
         m1_acks += int'(sn_ack[1]);
         other_acks += int'(sn_ack[0]) + int'(sn_ack[2]);
         if (c == 0) chk("wr_grant_c0", sn_grant, 3'b000);
         if (c == 1) begin
            chk("wr_grant_c1", sn_grant, 3'b010);
            chk("wr_s_addr", sn_saddr, 32'h0200_0000);
            chk("wr_s_wdata", sn_swdata, 32'h1234_5678);
            chk("wr_s_sel", sn_ssel, 4'hF);
            chk("wr_s_we", sn_swe, 1'b1);
         end
         if (c == 3) chk("wr_ack_c3", sn_ack, 3'b010);
      end
      chk("wr_m1_pulses", m1_acks, 1);
      chk("wr_other_acks", other_acks, 0);
      we = '0;

      // m2 four beats in one cycle while m0 waits
      cyc = 3'b100; stb = 3'b100; s_ack = 1'b0;
      tick();
      cyc = 3'b101; stb = 3'b101; s_ack = 1'b1;
      for (int b = 0; b < 4; b++) begin
         tick();
         chk($sformatf("burst_ack%0d", b), sn_ack, 3'b100);
         chk($sformatf("burst_grant%0d", b), sn_grant, 3'b100);
      end
      cyc = 3'b001; stb = 3'b001; s_ack = 1'b0;
      tick();
      chk("burst_end_grant", sn_grant, 3'b100);
      tick();
      chk("burst_idle_grant", sn_grant, 3'b000);
      tick();
      chk("burst_m0_grant", sn_grant, 3'b001);
      drain_all();

      // Reset mid-transaction while m1 strobes
      cyc = 3'b010; stb = 3'b010; s_ack = 1'b0;
      tick();
      tick();
      chk("mid_grant_before", sn_grant, 3'b010);
      s_ack = 1'b1;
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      chk("mid_rst_s_cyc", s_cyc, 1'b0);
      chk("mid_rst_s_stb", s_stb, 1'b0);
      chk("mid_rst_grant", grant, 3'b000);
      chk("mid_rst_ack", ack_o, 3'b000);
      @(posedge clk);
      #1;
      chk("mid_rst_hold", grant, 3'b000);
      rst = 1'b1;
      cyc = 3'b011; stb = 3'b011; s_ack = 1'b0;
      tick();
      tick();
      chk("post_rst_grant", sn_grant, 3'b001);
      drain_all();

`ifdef WB_ARB_TIMEOUT_EN
      // Hung slave on an m0 read: watchdog terminates after 8 stalls
      cyc = 3'b001; stb = 3'b001; s_ack = 1'b0; s_rdata = 32'h0BAD_0BAD;
      tick();
      cyc = 3'b011; stb = 3'b011;
      stalled = 0; seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         tick();
         if (sn_to) seen = 1'b1;
         else if (sn_sstb) stalled++;
      end
      chk("to_seen", seen, 1'b1);
      chk("to_stalls", stalled, TO);
      chk("to_ack", sn_ack, 3'b001);
      chk("to_rdata", sn_rd[0], 32'hDEAD_BEEF);
      chk("to_s_cyc", sn_scyc, 1'b0);
      cyc = 3'b010; stb = 3'b010;
      tick();
      chk("drain_timeout", sn_to, 1'b0);
      chk("drain_grant", sn_grant, 3'b001);
      chk("drain_s_cyc", sn_scyc, 1'b0);
      tick();
      chk("drain_idle", sn_grant, 3'b000);
      tick();
      chk("drain_m1_grant", sn_grant, 3'b010);
      drain_all();
`else
      // Hung slave without watchdog: bus stays held
      cyc = 3'b001; stb = 3'b001; s_ack = 1'b0;
      tick();
      ntos = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         ntos += int'(sn_to);
      end
      chk("hang_timeouts", ntos, 0);
      chk("hang_s_cyc", sn_scyc, 1'b1);
      chk("hang_grant", sn_grant, 3'b001);
      s_ack = 1'b1;
      tick();
      chk("hang_late_ack", sn_ack, 3'b001);
      drain_all();
`endif

      // Randomized traffic against the reference model
      for (int i = 0; i < 3; i++) begin act[i] = 1'b0; beats[i] = 0; end
      for (int n = 0; n < 2000; n++) begin
         for (int i = 0; i < 3; i++) begin
            if (act[i]) begin
               if (e_ack[i] && stb[i] && cyc[i]) beats[i]--;
               if (e_to && e_ack[i]) beats[i] = 0;
               if (beats[i] <= 0) begin
                  act[i] = 1'b0; cyc[i] = 1'b0; stb[i] = 1'b0;
               end else if (mo != i && $urandom_range(15) == 0) begin
                  act[i] = 1'b0; cyc[i] = 1'b0; stb[i] = 1'b0;
               end else begin
                  stb[i] = ($urandom_range(3) != 0);
               end
            end else if ($urandom_range(3) == 0) begin
               act[i] = 1'b1; beats[i] = $urandom_range(3, 1);
               cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = 1'($urandom_range(1));
               addr[i] = $urandom; wdata[i] = $urandom; sel[i] = 4'($urandom);
            end
         end
         s_ack = ($urandom_range(2) == 0);
         s_rdata = $urandom;
         tick();
      end
      drain_all();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
